// File: rtl/pc_fetch_unit_pkg.sv
// Shared types and constants for the PC fetch sequencer.
// Holds the FSM state encoding, the fault code values and the instruction width.
// Also holds the branch offset helper, so the sub-module and the top agree on scaling.
package pc_fetch_unit_pkg;

  localparam int INSTR_W = 32;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_EXEC = 2'd1,
    S_HALT = 2'd2
  } state_t;

  typedef logic [1:0] fault_t;

  localparam fault_t FAULT_NONE     = 2'b00;
  localparam fault_t FAULT_TIMEOUT  = 2'b01;
  localparam fault_t FAULT_MISALIGN = 2'b10;

  // A branch immediate counts words. Shifting it left by two gives a byte offset.
  // The result wraps modulo 2^32.
  function automatic logic [INSTR_W-1:0] branch_offset(input logic [INSTR_W-1:0] imm);
    return imm << 2;
  endfunction

endpackage

// File: rtl/pc_fetch_unit_if.sv
// Instruction-memory request/acknowledge port of the fetch unit.
// master: fetch side, drives imem_req/imem_addr and samples imem_ack/imem_rdata.
// slave: memory side. imem_rdata is only meaningful in a cycle where imem_ack is high.
interface pc_fetch_unit_if;
  import pc_fetch_unit_pkg::*;

  logic               imem_req;
  logic [INSTR_W-1:0] imem_addr;
  logic               imem_ack;
  logic [INSTR_W-1:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );

endinterface

// File: rtl/pc_fetch_unit_next_pc_logic.sv
// Next-PC target selection: jr, then j/jal, then a taken beq/bne, else pc+4.
// Latency: purely combinational, no state.
// Backpressure: none; the caller decides when the result is committed.
// Ports: pc in; decoder controls, zero, branch_imm, jump_index, rs_data in; pc_plus4, next_pc out.
module pc_fetch_unit_next_pc_logic
  import pc_fetch_unit_pkg::*;
(
  input  logic [INSTR_W-1:0] pc,
  input  logic               Branch,
  input  logic               BranchNot,
  input  logic               Jump,
  input  logic               JumpReg,
  input  logic               zero,
  input  logic [INSTR_W-1:0] branch_imm,
  input  logic [25:0]        jump_index,
  input  logic [INSTR_W-1:0] rs_data,
  output logic [INSTR_W-1:0] pc_plus4,
  output logic [INSTR_W-1:0] next_pc
);

  logic take_branch;

  assign pc_plus4    = pc + 32'd4;
  assign take_branch = (Branch & zero) | (BranchNot & ~zero);

  always_comb begin
    next_pc = pc_plus4;
    if (JumpReg) begin
      next_pc = rs_data;
    end else if (Jump) begin
      // The jump region comes from the delay-slot address (pc+4), not from pc.
      next_pc = {pc_plus4[31:28], jump_index, 2'b00};
    end else if (take_branch) begin
      next_pc = pc_plus4 + branch_offset(branch_imm);
    end
  end

endmodule

// File: rtl/pc_fetch_unit.sv
// Fetch sequencer. It holds the PC, fetches each word over req/ack and presents it for one execute cycle.
// Latency: a fetch takes at least one request cycle and then one execute cycle, so at best 2 cycles per instruction.
// Backpressure: it waits in the request state until imem_ack arrives; after IMEM_TIMEOUT cycles it faults and halts.
// Ports: clk/reset; imem (pc_fetch_unit_if.master); instr, instr_valid, pc, pc_plus4 to the datapath;
//        Branch/BranchNot/Jump/JumpReg/zero/branch_imm/jump_index/rs_data from the decoder and ALU; halted, fault_code.
// Build option: define PC_ALIGN_CHECK_EN to halt on a misaligned jump target. Without it, the low target bits are cleared.
module pc_fetch_unit
  import pc_fetch_unit_pkg::*;
#(
  parameter logic [INSTR_W-1:0] RESET_PC     = 32'h0000_0000,
  parameter int                 IMEM_TIMEOUT = 16
) (
  input  logic                clk,
  input  logic                reset,
  pc_fetch_unit_if.master     imem,
  output logic [INSTR_W-1:0]  instr,
  output logic                instr_valid,
  output logic [INSTR_W-1:0]  pc,
  output logic [INSTR_W-1:0]  pc_plus4,
  input  logic                Branch,
  input  logic                BranchNot,
  input  logic                Jump,
  input  logic                JumpReg,
  input  logic                zero,
  input  logic [INSTR_W-1:0]  branch_imm,
  input  logic [25:0]         jump_index,
  input  logic [INSTR_W-1:0]  rs_data,
  output logic                halted,
  output fault_t              fault_code
);

  localparam logic [7:0] TIMEOUT_LAST = 8'(IMEM_TIMEOUT - 1);

  state_t             state_q, state_d;
  logic [INSTR_W-1:0] pc_q, pc_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [7:0]         cnt_q, cnt_d;
  logic               halted_q, halted_d;
  fault_t             fault_q, fault_d;

  logic               req_c;
  logic               valid_c;
  logic [INSTR_W-1:0] next_pc_raw;

  pc_fetch_unit_next_pc_logic u_next_pc_logic (
    .pc         (pc_q),
    .Branch     (Branch),
    .BranchNot  (BranchNot),
    .Jump       (Jump),
    .JumpReg    (JumpReg),
    .zero       (zero),
    .branch_imm (branch_imm),
    .jump_index (jump_index),
    .rs_data    (rs_data),
    .pc_plus4   (pc_plus4),
    .next_pc    (next_pc_raw)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_REQ;
      pc_q     <= RESET_PC;
      instr_q  <= '0;
      cnt_q    <= '0;
      halted_q <= 1'b0;
      fault_q  <= FAULT_NONE;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      instr_q  <= instr_d;
      cnt_q    <= cnt_d;
      halted_q <= halted_d;
      fault_q  <= fault_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    instr_d  = instr_q;
    cnt_d    = cnt_q;
    halted_d = halted_q;
    fault_d  = fault_q;
    req_c    = 1'b0;
    valid_c  = 1'b0;

    case (state_q)
      S_REQ: begin
        req_c = 1'b1;
        // An ack on the last allowed cycle still counts, so the ack is checked first.
        if (imem.imem_ack) begin
          instr_d = imem.imem_rdata;
          cnt_d   = '0;
          state_d = S_EXEC;
        end else if (cnt_q == TIMEOUT_LAST) begin
          fault_d  = FAULT_TIMEOUT;
          halted_d = 1'b1;
          state_d  = S_HALT;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      S_EXEC: begin
        valid_c = 1'b1;
`ifdef PC_ALIGN_CHECK_EN
        // Only a jr can produce a misaligned target. Keep the PC of the faulting instruction.
        if (next_pc_raw[1:0] != 2'b00) begin
          fault_d  = FAULT_MISALIGN;
          halted_d = 1'b1;
          state_d  = S_HALT;
        end else begin
          pc_d    = next_pc_raw;
          state_d = S_REQ;
        end
`else
        pc_d    = next_pc_raw & ~32'h0000_0003;
        state_d = S_REQ;
`endif
      end

      S_HALT: begin
        state_d = S_HALT;
      end

      default: begin
        state_d = S_REQ;
      end
    endcase
  end

  // The request is gated by reset so that it drops at once when reset asserts mid-handshake.
  assign imem.imem_req  = req_c & ~reset;
  assign imem.imem_addr = pc_q;

  assign instr       = instr_q;
  assign instr_valid = valid_c;
  assign pc          = pc_q;
  assign halted      = halted_q;
  assign fault_code  = fault_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
module tb_pc_fetch_unit;

  logic        clk;
  logic        reset;
  logic [31:0] instr;
  logic        instr_valid;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        Branch, BranchNot, Jump, JumpReg, zero;
  logic [31:0] branch_imm;
  logic [25:0] jump_index;
  logic [31:0] rs_data;
  logic        halted;
  logic [1:0]  fault_code;
  logic        ack_en;

  int tests_run;
  int tests_failed;

  pc_fetch_unit_if bus ();

  // Memory model: it acks a request whenever that is enabled. Its data word is the address XOR a constant.
  assign bus.imem_ack   = ack_en & bus.imem_req;
  assign bus.imem_rdata = bus.imem_addr ^ 32'hDEAD_BEEF;

  pc_fetch_unit #(
    .RESET_PC     (32'h0000_0000),
    .IMEM_TIMEOUT (4)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .imem        (bus),
    .instr       (instr),
    .instr_valid (instr_valid),
    .pc          (pc),
    .pc_plus4    (pc_plus4),
    .Branch      (Branch),
    .BranchNot   (BranchNot),
    .Jump        (Jump),
    .JumpReg     (JumpReg),
    .zero        (zero),
    .branch_imm  (branch_imm),
    .jump_index  (jump_index),
    .rs_data     (rs_data),
    .halted      (halted),
    .fault_code  (fault_code)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hDEAD_BEEF;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_ctrl();
    Branch = 1'b0; BranchNot = 1'b0; Jump = 1'b0; JumpReg = 1'b0; zero = 1'b0;
    branch_imm = '0; jump_index = '0; rs_data = '0;
  endtask

  // Call it in the request state with acks enabled. It uses one jr instruction to land on target.
  task automatic goto_pc(input logic [31:0] target);
    clear_ctrl();
    JumpReg = 1'b1; rs_data = target;
    tick(); tick();
    clear_ctrl();
  endtask

  task automatic exec_one();
    tick(); tick();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #2;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; ack_en = 1'b1; clear_ctrl();
    #2;
    tests_run++; if (pc !== 32'h0) begin tests_failed++; $display("FAIL reset_pc: got %h want %h", pc, 32'h0); end
    tests_run++; if (bus.imem_req !== 1'b0) begin tests_failed++; $display("FAIL reset_req: got %b want 0", bus.imem_req); end
    tests_run++; if (instr !== 32'h0) begin tests_failed++; $display("FAIL reset_instr: got %h want 0", instr); end
    tests_run++; if ({instr_valid, halted, fault_code} !== 4'b0000) begin tests_failed++; $display("FAIL reset_flags: got %b want 0000", {instr_valid, halted, fault_code}); end
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    tests_run++; if (bus.imem_req !== 1'b1) begin tests_failed++; $display("FAIL reset_release_req: got %b want 1", bus.imem_req); end
    tests_run++; if (bus.imem_addr !== 32'h0) begin tests_failed++; $display("FAIL reset_release_addr: got %h want 0", bus.imem_addr); end
  endtask

  task automatic test_sequential();
    logic [31:0] exp_pc;
    for (int i = 0; i < 4; i++) begin
      exp_pc = 32'(i * 4);
      tick();
      tests_run++; if (instr_valid !== 1'b1) begin tests_failed++; $display("FAIL seq_valid_hi[%0d]: got %b want 1", i, instr_valid); end
      tests_run++; if (instr !== mem_word(exp_pc)) begin tests_failed++; $display("FAIL seq_instr[%0d]: got %h want %h", i, instr, mem_word(exp_pc)); end
      tests_run++; if (pc !== exp_pc) begin tests_failed++; $display("FAIL seq_pc[%0d]: got %h want %h", i, pc, exp_pc); end
      tick();
      tests_run++; if (instr_valid !== 1'b0) begin tests_failed++; $display("FAIL seq_valid_lo[%0d]: got %b want 0", i, instr_valid); end
      tests_run++; if (pc !== exp_pc + 32'd4) begin tests_failed++; $display("FAIL seq_next_pc[%0d]: got %h want %h", i, pc, exp_pc + 32'd4); end
    end
  endtask

  task automatic test_branch();
    goto_pc(32'h10);
    Branch = 1'b1; zero = 1'b1; branch_imm = 32'hFFFF_FFFE;
    exec_one(); clear_ctrl();
    tests_run++; if (pc !== 32'h0C) begin tests_failed++; $display("FAIL beq_taken: got %h want %h", pc, 32'h0C); end
    goto_pc(32'h10);
    Branch = 1'b1; zero = 1'b0; branch_imm = 32'hFFFF_FFFE;
    exec_one(); clear_ctrl();
    tests_run++; if (pc !== 32'h14) begin tests_failed++; $display("FAIL beq_not_taken: got %h want %h", pc, 32'h14); end
    goto_pc(32'h10);
    BranchNot = 1'b1; zero = 1'b0; branch_imm = 32'hFFFF_FFFE;
    exec_one(); clear_ctrl();
    tests_run++; if (pc !== 32'h0C) begin tests_failed++; $display("FAIL bne_taken: got %h want %h", pc, 32'h0C); end
    goto_pc(32'h10);
    BranchNot = 1'b1; zero = 1'b1; branch_imm = 32'h0000_0003;
    exec_one(); clear_ctrl();
    tests_run++; if (pc !== 32'h14) begin tests_failed++; $display("FAIL bne_not_taken: got %h want %h", pc, 32'h14); end
  endtask

  task automatic test_jump();
    goto_pc(32'h0040_0000);
    Jump = 1'b1; jump_index = 26'h000_0100;
    exec_one(); clear_ctrl();
    tests_run++; if (pc !== 32'h0000_0400) begin tests_failed++; $display("FAIL jump: got %h want %h", pc, 32'h0000_0400); end
    goto_pc(32'hF000_0010);
    Jump = 1'b1; jump_index = 26'h3FF_FFFF;
    exec_one(); clear_ctrl();
    tests_run++; if (pc !== 32'hFFFF_FFFC) begin tests_failed++; $display("FAIL jump_region: got %h want %h", pc, 32'hFFFF_FFFC); end
    tests_run++; if (pc_plus4 !== 32'h0) begin tests_failed++; $display("FAIL pc_plus4_wrap: got %h want 0", pc_plus4); end
    exec_one();
    tests_run++; if (pc !== 32'h0) begin tests_failed++; $display("FAIL seq_wrap: got %h want 0", pc); end
    JumpReg = 1'b1; Jump = 1'b1; rs_data = 32'h80; jump_index = 26'h000_0100;
    exec_one(); clear_ctrl();
    tests_run++; if (pc !== 32'h80) begin tests_failed++; $display("FAIL jr_priority: got %h want %h", pc, 32'h80); end
    tests_run++; if (pc_plus4 !== 32'h84) begin tests_failed++; $display("FAIL pc_plus4: got %h want %h", pc_plus4, 32'h84); end
  endtask

  task automatic test_align();
    goto_pc(32'h40);
    JumpReg = 1'b1; rs_data = 32'h102;
    exec_one(); clear_ctrl();
`ifdef PC_ALIGN_CHECK_EN
    tests_run++; if (pc !== 32'h40) begin tests_failed++; $display("FAIL misalign_pc: got %h want %h", pc, 32'h40); end
    tests_run++; if ({halted, fault_code} !== 3'b110) begin tests_failed++; $display("FAIL misalign_fault: got %b want 110", {halted, fault_code}); end
    tests_run++; if (bus.imem_req !== 1'b0) begin tests_failed++; $display("FAIL misalign_req: got %b want 0", bus.imem_req); end
`else
    tests_run++; if (pc !== 32'h100) begin tests_failed++; $display("FAIL align_force: got %h want %h", pc, 32'h100); end
    tests_run++; if ({halted, fault_code} !== 3'b000) begin tests_failed++; $display("FAIL align_nofault: got %b want 000", {halted, fault_code}); end
`endif
    ack_en = 1'b1;
    do_reset();
  endtask

  task automatic test_timeout();
    ack_en = 1'b0;
    do_reset();
    tick(); tick(); tick();
    tests_run++; if ({halted, bus.imem_req} !== 2'b01) begin tests_failed++; $display("FAIL timeout_early: got %b want 01", {halted, bus.imem_req}); end
    tick();
    tests_run++; if (halted !== 1'b1) begin tests_failed++; $display("FAIL timeout_halted: got %b want 1", halted); end
    tests_run++; if (fault_code !== 2'b01) begin tests_failed++; $display("FAIL timeout_code: got %b want 01", fault_code); end
    tests_run++; if (bus.imem_req !== 1'b0) begin tests_failed++; $display("FAIL timeout_req: got %b want 0", bus.imem_req); end
    ack_en = 1'b1; JumpReg = 1'b1; rs_data = 32'h200;
    tick(); tick(); tick(); clear_ctrl();
    tests_run++; if (pc !== 32'h0) begin tests_failed++; $display("FAIL halt_pc_frozen: got %h want 0", pc); end
    tests_run++; if ({instr_valid, halted, fault_code, bus.imem_req} !== 5'b01010) begin tests_failed++; $display("FAIL halt_frozen: got %b want 01010", {instr_valid, halted, fault_code, bus.imem_req}); end
  endtask

  task automatic test_delayed_ack();
    ack_en = 1'b0;
    do_reset();
    tick(); tick(); tick();
    ack_en = 1'b1;
    tick();
    tests_run++; if ({instr_valid, halted, fault_code} !== 4'b1000) begin tests_failed++; $display("FAIL late_ack_flags: got %b want 1000", {instr_valid, halted, fault_code}); end
    tests_run++; if (instr !== mem_word(32'h0)) begin tests_failed++; $display("FAIL late_ack_instr: got %h want %h", instr, mem_word(32'h0)); end
    tick();
    tests_run++; if (pc !== 32'h4) begin tests_failed++; $display("FAIL late_ack_next: got %h want %h", pc, 32'h4); end
  endtask

  task automatic test_mid_reset();
    JumpReg = 1'b1; rs_data = 32'h24;
    tick();
    ack_en = 1'b0;
    tick(); clear_ctrl();
    tick();
    tests_run++; if ({bus.imem_req, pc} !== {1'b1, 32'h24}) begin tests_failed++; $display("FAIL wait_at_24: got %b/%h want 1/%h", bus.imem_req, pc, 32'h24); end
    #2;
    reset = 1'b1;
    #1;
    tests_run++; if (bus.imem_req !== 1'b0) begin tests_failed++; $display("FAIL midreset_req: got %b want 0", bus.imem_req); end
    tests_run++; if (pc !== 32'h0) begin tests_failed++; $display("FAIL midreset_pc: got %h want 0", pc); end
    @(posedge clk);
    #1;
    reset = 1'b0; ack_en = 1'b1;
    #1;
    tests_run++; if ({bus.imem_req, bus.imem_addr} !== {1'b1, 32'h0}) begin tests_failed++; $display("FAIL restart_req: got %b/%h want 1/0", bus.imem_req, bus.imem_addr); end
    tick();
    tests_run++; if ({instr_valid, instr} !== {1'b1, mem_word(32'h0)}) begin tests_failed++; $display("FAIL restart_fetch: got %b/%h want 1/%h", instr_valid, instr, mem_word(32'h0)); end
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    reset = 1'b1;
    ack_en = 1'b1;
    clear_ctrl();
    test_reset();
    test_sequential();
    test_branch();
    test_jump();
    test_align();
    test_timeout();
    test_delayed_ack();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
